// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: ALU op codes, MIPS opcode/funct/rt fields,
// HI/LO write modes, FSM states and the decode result record.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_SPECIAL3 = 6'h1F;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MOVZ  = 6'h0A;
  localparam logic [5:0] F_MOVN  = 6'h0B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [5:0] F2_MADD = 6'h00;
  localparam logic [5:0] F2_MUL  = 6'h02;
  localparam logic [5:0] F2_MSUB = 6'h04;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  localparam logic [1:0] HILO_WRITE = 2'b00;
  localparam logic [1:0] HILO_ACC   = 2'b01;
  localparam logic [1:0] HILO_SUB   = 2'b10;
  localparam logic [1:0] HILO_GPR   = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       is_multi;
    logic [1:0] hilo_mode;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational opcode/funct/rt table; unknown encodings report illegal with op ADD.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output dec_t       dec
);

  always_comb begin
    dec = '{op: ALU_ADD, is_multi: 1'b0, hilo_mode: HILO_WRITE, illegal: 1'b0};
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_AND:                                 dec.op = ALU_AND;
          F_OR, F_MFHI, F_MFLO, F_MTHI, F_MTLO:  dec.op = ALU_OR;
          F_XOR:                                 dec.op = ALU_XOR;
          F_NOR:                                 dec.op = ALU_NOR;
          F_SLL, F_SLLV:                         dec.op = ALU_SLL;
          F_SRL, F_SRLV:                         dec.op = ALU_SRL;
          F_SRA, F_SRAV:                         dec.op = ALU_SRA;
          F_ADD, F_ADDU, F_JR:                   dec.op = ALU_ADD;
          F_SUB, F_SUBU, F_SLT, F_SLTU, F_MOVZ, F_MOVN: dec.op = ALU_SUB;
          F_MULT, F_MULTU: begin
            dec.op       = ALU_MUL;
            dec.is_multi = 1'b1;
          end
          default:                               dec.illegal = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        dec.op       = ALU_MUL;
        dec.is_multi = 1'b1;
        case (funct)
          F2_MADD: dec.hilo_mode = HILO_ACC;
          F2_MSUB: dec.hilo_mode = HILO_SUB;
          F2_MUL:  dec.hilo_mode = HILO_GPR;
          default: begin
            dec.op       = ALU_ADD;
            dec.is_multi = 1'b0;
            dec.illegal  = 1'b1;
          end
        endcase
      end
      OP_SPECIAL3:                        dec.op = ALU_AND;
      OP_ANDI:                            dec.op = ALU_AND;
      OP_ORI:                             dec.op = ALU_OR;
      OP_XORI:                            dec.op = ALU_XOR;
      OP_ADDI, OP_ADDIU, OP_LUI, OP_LW, OP_LH, OP_LB,
      OP_SW, OP_SH, OP_SB, OP_J, OP_JAL:  dec.op = ALU_ADD;
      OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE,
      OP_BLEZ, OP_BGTZ:                   dec.op = ALU_SUB;
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ) dec.op = ALU_SUB;
        else                                dec.illegal = 1'b1;
      end
      default:                            dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ID/EX ALU control: decode + output register (1 cycle when REG_OUT=1), multiply counter FSM.
// ready_out drops while a multiply is in flight or while EX stalls a valid output.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int MUL_LAT = 3,
  parameter int REG_OUT = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               stall_in,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               valid_out,
  output logic               mul_start,
  output logic               hilo_we,
  output logic [1:0]         hilo_mode,
  output logic               illegal
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  dec_t       dec;
  state_e     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept, dec_wr;
  logic [3:0] op_q;
  logic [1:0] mode_q;
  logic       vld_q, ill_q, start_q, hilo_wr_q, hilo_done;

  alu_ctrl_decode u_decode (
    .opcode (Opcode),
    .funct  (funct),
    .rt     (rt),
    .dec    (dec)
  );

  assign ready_out = (REG_OUT != 0) ? ((state == ST_IDLE) && (!vld_q || !stall_in))
                                    : ((state == ST_IDLE) && !stall_in);
  assign accept    = valid_in && ready_out;
  assign dec_wr    = dec.is_multi && (dec.hilo_mode != HILO_GPR);

  // MUL_LAT=1 never leaves IDLE; the single cycle is carried by mul_start alone.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_IDLE) begin
      if (accept && dec.is_multi && (MUL_LAT > 1)) begin
        state_nxt = ST_MUL_BUSY;
        cnt_nxt   = CNT_INIT;
      end
    end else begin
      if (cnt != 4'd0)    cnt_nxt   = cnt - 4'd1;
      else if (!stall_in) state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // hilo_done keeps hilo_we to one pulse when a stall parks the FSM at count 0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      start_q   <= 1'b0;
      hilo_wr_q <= 1'b0;
      hilo_done <= 1'b0;
    end else begin
      start_q <= accept && dec.is_multi;
      if (accept && dec.is_multi) begin
        hilo_wr_q <= dec_wr;
        hilo_done <= 1'b0;
      end else if (hilo_we) begin
        hilo_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_q   <= 4'd0;
      mode_q <= HILO_WRITE;
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= dec.op;
      mode_q <= dec.hilo_mode;
      vld_q  <= 1'b1;
      ill_q  <= dec.illegal;
    end else if (!(vld_q && stall_in)) begin
      vld_q  <= 1'b0;
      ill_q  <= 1'b0;
    end
  end

  // op/mode stay put after valid_out drops so EX sees hilo_mode at the final multiply cycle.
  assign ALUOp     = (REG_OUT != 0) ? ALUOP_W'(op_q) : ALUOP_W'(dec.op);
  assign valid_out = (REG_OUT != 0) ? vld_q : accept;
  assign illegal   = (REG_OUT != 0) ? ill_q : (accept && dec.illegal);
  assign hilo_mode = ((REG_OUT != 0) || (state == ST_MUL_BUSY)) ? mode_q : dec.hilo_mode;
  assign mul_start = (REG_OUT != 0) ? start_q : (accept && dec.is_multi);
  assign hilo_we   = (MUL_LAT == 1)
                   ? (mul_start && ((REG_OUT != 0) ? hilo_wr_q : dec_wr))
                   : ((state == ST_MUL_BUSY) && (cnt == 4'd0) && hilo_wr_q && !hilo_done);

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench: default instance (4/3/1) and an ALUOP_W=6, MUL_LAT=1 instance.
module tb_alu_control_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [5:0] Opcode, funct;
  logic [4:0] rt;
  logic       valid_in, stall_in;
  logic       ready_out, valid_out, mul_start, hilo_we, illegal;
  logic [3:0] ALUOp;
  logic [1:0] hilo_mode;

  logic [5:0] p_Opcode, p_funct;
  logic [4:0] p_rt;
  logic       p_valid_in, p_stall_in;
  logic       p_ready_out, p_valid_out, p_mul_start, p_hilo_we, p_illegal;
  logic [5:0] p_ALUOp;
  logic [1:0] p_hilo_mode;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] o;
    logic [5:0] f;
    logic [4:0] r;
    logic [3:0] a;
    logic       ill;
  } vec_t;
  vec_t tbl[$];

  always #5 Clk = ~Clk;

  alu_control_seq #(.ALUOP_W(4), .MUL_LAT(3), .REG_OUT(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .funct(funct), .rt(rt),
    .valid_in(valid_in), .ready_out(ready_out), .stall_in(stall_in),
    .ALUOp(ALUOp), .valid_out(valid_out), .mul_start(mul_start),
    .hilo_we(hilo_we), .hilo_mode(hilo_mode), .illegal(illegal)
  );

  alu_control_seq #(.ALUOP_W(6), .MUL_LAT(1), .REG_OUT(1)) u_dut_p (
    .Clk(Clk), .Rst(Rst), .Opcode(p_Opcode), .funct(p_funct), .rt(p_rt),
    .valid_in(p_valid_in), .ready_out(p_ready_out), .stall_in(p_stall_in),
    .ALUOp(p_ALUOp), .valid_out(p_valid_out), .mul_start(p_mul_start),
    .hilo_we(p_hilo_we), .hilo_mode(p_hilo_mode), .illegal(p_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                     input logic [3:0] a, input logic ill);
    vec_t v;
    v.o = o; v.f = f; v.r = r; v.a = a; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    Opcode = o; funct = f; rt = r; valid_in = 1'b1;
  endtask

  // One multiply-class op with MUL_LAT=3: accept at t, checks at t+1..t+4.
  task automatic run_mul(input string nm, input logic [5:0] o, input logic [5:0] f,
                         input logic [1:0] mode, input logic we);
    drive(o, f, 5'd0);
    #1;
    chk({nm, "_rdy0"}, 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    chk({nm, "_start1"}, 32'(mul_start), 32'd1);
    chk({nm, "_op1"}, 32'(ALUOp), 32'hF);
    chk({nm, "_rdy1"}, 32'(ready_out), 32'd0);
    chk({nm, "_we1"}, 32'(hilo_we), 32'd0);
    tick();
    chk({nm, "_start2"}, 32'(mul_start), 32'd0);
    chk({nm, "_rdy2"}, 32'(ready_out), 32'd0);
    chk({nm, "_we2"}, 32'(hilo_we), 32'd0);
    tick();
    chk({nm, "_rdy3"}, 32'(ready_out), 32'd0);
    chk({nm, "_we3"}, 32'(hilo_we), 32'(we));
    chk({nm, "_mode3"}, 32'(hilo_mode), 32'(mode));
    tick();
    chk({nm, "_rdy4"}, 32'(ready_out), 32'd1);
    chk({nm, "_we4"}, 32'(hilo_we), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int we_seen;
    Rst = 1'b1; Opcode = '0; funct = '0; rt = '0; valid_in = 1'b0; stall_in = 1'b0;
    p_Opcode = '0; p_funct = '0; p_rt = '0; p_valid_in = 1'b0; p_stall_in = 1'b0;

    // SPECIAL
    add(6'h00, 6'h24, 5'd0, 4'b0000, 1'b0);
    add(6'h00, 6'h25, 5'd0, 4'b0001, 1'b0);
    add(6'h00, 6'h10, 5'd0, 4'b0001, 1'b0);
    add(6'h00, 6'h12, 5'd0, 4'b0001, 1'b0);
    add(6'h00, 6'h11, 5'd0, 4'b0001, 1'b0);
    add(6'h00, 6'h13, 5'd0, 4'b0001, 1'b0);
    add(6'h00, 6'h26, 5'd0, 4'b0011, 1'b0);
    add(6'h00, 6'h27, 5'd0, 4'b0111, 1'b0);
    add(6'h00, 6'h00, 5'd0, 4'b0100, 1'b0);
    add(6'h00, 6'h04, 5'd0, 4'b0100, 1'b0);
    add(6'h00, 6'h02, 5'd0, 4'b0101, 1'b0);
    add(6'h00, 6'h06, 5'd0, 4'b0101, 1'b0);
    add(6'h00, 6'h03, 5'd0, 4'b1000, 1'b0);
    add(6'h00, 6'h07, 5'd0, 4'b1000, 1'b0);
    add(6'h00, 6'h20, 5'd0, 4'b0010, 1'b0);
    add(6'h00, 6'h21, 5'd0, 4'b0010, 1'b0);
    add(6'h00, 6'h08, 5'd0, 4'b0010, 1'b0);
    add(6'h00, 6'h22, 5'd0, 4'b0110, 1'b0);
    add(6'h00, 6'h23, 5'd0, 4'b0110, 1'b0);
    add(6'h00, 6'h2A, 5'd0, 4'b0110, 1'b0);
    add(6'h00, 6'h2B, 5'd0, 4'b0110, 1'b0);
    add(6'h00, 6'h0A, 5'd0, 4'b0110, 1'b0);
    add(6'h00, 6'h0B, 5'd0, 4'b0110, 1'b0);
    add(6'h00, 6'h3F, 5'd0, 4'b0010, 1'b1);
    // SPECIAL3, I/J types, REGIMM
    add(6'h1F, 6'h20, 5'd0, 4'b0000, 1'b0);
    add(6'h0C, 6'h00, 5'd0, 4'b0000, 1'b0);
    add(6'h0D, 6'h00, 5'd0, 4'b0001, 1'b0);
    add(6'h0E, 6'h00, 5'd0, 4'b0011, 1'b0);
    add(6'h08, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h09, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h0F, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h23, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h21, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h20, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h2B, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h29, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h28, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h02, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h03, 6'h00, 5'd0, 4'b0010, 1'b0);
    add(6'h0A, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h0B, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h04, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h05, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h06, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h07, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h01, 6'h00, 5'd0, 4'b0110, 1'b0);
    add(6'h01, 6'h00, 5'd1, 4'b0110, 1'b0);
    add(6'h01, 6'h00, 5'd2, 4'b0010, 1'b1);
    add(6'h3F, 6'h00, 5'd0, 4'b0010, 1'b1);
    add(6'h1C, 6'h3F, 5'd0, 4'b0010, 1'b1);

    // Reset state
    @(negedge Clk);
    chk("rst_aluop", 32'(ALUOp), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_mode", 32'(hilo_mode), 32'd0);
    chk("rst_we", 32'(hilo_we), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    tick();

    // Table sweep, back to back
    foreach (tbl[i]) begin
      drive(tbl[i].o, tbl[i].f, tbl[i].r);
      #1;
      chk($sformatf("tbl%0d_rdy", i), 32'(ready_out), 32'd1);
      tick();
      chk($sformatf("tbl%0d_op", i), 32'(ALUOp), 32'(tbl[i].a));
      chk($sformatf("tbl%0d_ill", i), 32'(illegal), 32'(tbl[i].ill));
      chk($sformatf("tbl%0d_vld", i), 32'(valid_out), 32'd1);
      chk($sformatf("tbl%0d_we", i), 32'(hilo_we), 32'd0);
      chk($sformatf("tbl%0d_mode", i), 32'(hilo_mode), 32'd0);
    end
    valid_in = 1'b0;
    tick();
    chk("idle_vld", 32'(valid_out), 32'd0);

    // Explicit back-to-back addu, sub, or
    drive(6'h00, 6'h21, 5'd0);
    tick();
    chk("b2b_addu", 32'(ALUOp), 32'b0010);
    chk("b2b_rdy0", 32'(ready_out), 32'd1);
    drive(6'h00, 6'h22, 5'd0);
    tick();
    chk("b2b_sub", 32'(ALUOp), 32'b0110);
    chk("b2b_rdy1", 32'(ready_out), 32'd1);
    drive(6'h00, 6'h25, 5'd0);
    tick();
    chk("b2b_or", 32'(ALUOp), 32'b0001);
    chk("b2b_rdy2", 32'(ready_out), 32'd1);
    valid_in = 1'b0;
    tick();

    // Multiply class
    run_mul("madd", 6'h1C, 6'h00, 2'b01, 1'b1);
    run_mul("msub", 6'h1C, 6'h04, 2'b10, 1'b1);
    run_mul("mul", 6'h1C, 6'h02, 2'b11, 1'b0);
    run_mul("mult", 6'h00, 6'h18, 2'b00, 1'b1);

    // Stall for two cycles while valid_out=1
    drive(6'h00, 6'h24, 5'd0);
    tick();
    stall_in = 1'b1;
    drive(6'h00, 6'h25, 5'd0);
    #1;
    chk("stl1_vld", 32'(valid_out), 32'd1);
    chk("stl1_op", 32'(ALUOp), 32'b0000);
    chk("stl1_rdy", 32'(ready_out), 32'd0);
    tick();
    chk("stl2_vld", 32'(valid_out), 32'd1);
    chk("stl2_op", 32'(ALUOp), 32'b0000);
    chk("stl2_rdy", 32'(ready_out), 32'd0);
    tick();
    stall_in = 1'b0;
    #1;
    chk("stl3_op", 32'(ALUOp), 32'b0000);
    chk("stl3_rdy", 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
    chk("stl4_op", 32'(ALUOp), 32'b0001);
    chk("stl4_vld", 32'(valid_out), 32'd1);
    tick();
    chk("stl5_vld", 32'(valid_out), 32'd0);

    // Async reset in MUL_BUSY at count 1
    drive(6'h1C, 6'h00, 5'd0);
    tick();
    valid_in = 1'b0;
    tick();
    chk("prerst_mode", 32'(hilo_mode), 32'b01);
    #2;
    Rst = 1'b1;
    #1;
    chk("arst_op", 32'(ALUOp), 32'd0);
    chk("arst_vld", 32'(valid_out), 32'd0);
    chk("arst_start", 32'(mul_start), 32'd0);
    chk("arst_we", 32'(hilo_we), 32'd0);
    chk("arst_mode", 32'(hilo_mode), 32'd0);
    chk("arst_ill", 32'(illegal), 32'd0);
    chk("arst_rdy", 32'(ready_out), 32'd1);
    @(negedge Clk);
    Rst = 1'b0;
    we_seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (hilo_we) we_seen++;
    end
    chk("arst_no_we", 32'(we_seen), 32'd0);
    chk("arst_rdy_after", 32'(ready_out), 32'd1);

    // ALUOP_W=6, MUL_LAT=1 instance
    p_Opcode = 6'h00; p_funct = 6'h18; p_rt = 5'd0; p_valid_in = 1'b1;
    tick();
    p_Opcode = 6'h01; p_funct = 6'h00; p_rt = 5'd2;
    #1;
    chk("p_mult_op", 32'(p_ALUOp), 32'b001111);
    chk("p_mult_start", 32'(p_mul_start), 32'd1);
    chk("p_mult_we", 32'(p_hilo_we), 32'd1);
    chk("p_mult_rdy", 32'(p_ready_out), 32'd1);
    tick();
    p_valid_in = 1'b0;
    chk("p_regimm_ill", 32'(p_illegal), 32'd1);
    chk("p_regimm_op", 32'(p_ALUOp), 32'b000010);
    chk("p_regimm_we", 32'(p_hilo_we), 32'd0);
    chk("p_regimm_start", 32'(p_mul_start), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
